qed_dup_replay: RTL
===================

# qed_dup_replay

Duplicate-instruction replay stage for the SQED harness. It sits directly downstream of the instruction-constraint checker and directly upstream of the DUT fetch port. In original mode it passes each constrained instruction to the core and records it. Once `exec_dup` fires, it replays the recorded sequence as register- and memory-remapped duplicates, then raises `qed_ready` so the consistency check can fire.

## Interface
- `DEPTH`, 16: replay buffer entries; must be a power of 2, at least 2.
- `NOP_INSN`, 32'h0000007F: QED NOP encoding (opcode 7'b1111111).
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `ifu_qed_instruction`  in  32: constrained instruction from the harness.
- `exec_dup`  in  1: free (formal) input; requests the switch to duplicate mode.
- `stall_IF`  in  1: core fetch stall; while high, nothing is accepted or advanced.
- `qed_instruction`  out  32: instruction presented to the core.
- `qed_vld`  out  1: `qed_instruction` is a real (non-NOP) instruction.
- `qed_ready`  out  1: every recorded original has been replayed.
- `orig_count`  out  clog2(DEPTH)+1: number of originals recorded.

## Operation
- States: ORIG, DUP, DONE. Reset state is ORIG.
- An accept occurs on any cycle with `stall_IF`=0. No state or storage changes on a stalled cycle.
- In ORIG, on accept:
  - Input is non-NOP and `orig_count` < DEPTH: write the input at `wr_ptr`, increment `wr_ptr` and `orig_count`, output the input unchanged with `qed_vld`=1.
  - Input is NOP, or the buffer is full: output `NOP_INSN` with `qed_vld`=0; nothing is recorded. A full buffer forces NOPs until mode changes.
- ORIG→DUP: on an accept with `exec_dup`=1 and `orig_count`>0.
  - That cycle's input is discarded; it is not recorded.
  - That cycle outputs the remapped buffer entry 0.
  - If `exec_dup`=1 with `orig_count`=0, stay in ORIG and treat the cycle as a normal ORIG accept.
- In DUP, on accept:
  - Output remap(entry[`rd_ptr`]) with `qed_vld`=1, then increment `rd_ptr`.
  - The input is ignored.
  - When `rd_ptr`+1 == `orig_count`, go to DONE.
- In DONE: output `NOP_INSN`, `qed_vld`=0, `qed_ready`=1. DONE is left only by `rst`.
- `exec_dup` is ignored outside ORIG.
- Remap is decided by opcode. "Field f'" means f | 5'b10000, except that a field equal to 0 stays 0 (x0 is shared).
  - 0110011 (R-type): rd', rs1', rs2'.
  - 0010011 (OP-IMM), 1100111 (JALR), 0001111 (FENCE): rd', rs1'.
  - 0000011 (load): rd', rs1', and set bit 26 (imm += 64, upper memory half).
  - 0100011 (store): rs1', rs2', and set bit 26.
  - 1100011 (branch): rs1', rs2'.
  - 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL): rd'.
  - 1110011 (SYSTEM) and any other opcode: unchanged.
- `orig_count` saturates at DEPTH. Pointers are clog2(DEPTH) bits wide; `wr_ptr` never wraps because recording stops when full.

## Timing
- All outputs are registered and update on the clock edge after an accept. There is one cycle of latency from input to `qed_instruction`.
- On a stalled cycle all outputs hold their previous value.
- Reset values: `qed_instruction`=`NOP_INSN`, `qed_vld`=0, `qed_ready`=0, `orig_count`=0, state=ORIG, both pointers 0.
- `qed_ready` rises on the same edge on which the last duplicate appears on `qed_instruction`.
- `rst` asserted at any time, including mid-DUP or together with `exec_dup`, wins. The next cycle shows reset values, and buffer contents are treated as invalid.
- Duplicates appear at most one per accept. N originals take exactly N non-stalled cycles to replay.

## Test plan
- Record and replay one ADDI: input 0x00510093 (ADDI x1,x2,5), then `exec_dup`=1 on the next cycle.
  - First output: 0x00510093 with `qed_vld`=1.
  - Next output: 0x00590893 (x17,x18) with `qed_vld`=1; `qed_ready`=1 on that same edge.
- Load remap: LW x3,8(x0), 0x00802183, recorded then replayed.
  - Duplicate is 0x04802983 (rd=x19, imm=72, rs1 stays x0).
- Stall: `stall_IF`=1 for 3 cycles mid-DUP with 4 originals.
  - Output holds and `rd_ptr` is frozen.
  - Replay completes exactly 4 non-stalled cycles after entry to DUP.
- Full buffer: DEPTH+3 non-NOP inputs.
  - `orig_count`=16.
  - The last 3 inputs output `NOP_INSN` with `qed_vld`=0.
  - Replay emits exactly 16 duplicates.
- `exec_dup` with an empty buffer, and `exec_dup` together with `stall_IF`=1:
  - The state remains ORIG in both cases.
  - NOP inputs leave `orig_count` at 0.
- Reset mid-DUP after 2 of 5 replays:
  - Next cycle: `qed_instruction`=0x0000007F, `qed_vld`=0, `qed_ready`=0, `orig_count`=0, state ORIG.

Source files
------------

// File: rtl/qed_dup_replay.sv
// ---------------------------------------------------------------------------
// qed_dup_replay
//
// Duplicate-instruction replay stage for the SQED harness. Sits between the
// instruction-constraint checker and the core fetch port.
//
// ORIG mode: each constrained, non-NOP instruction is forwarded to the core
// and recorded in the replay buffer. Once exec_dup is seen with at least one
// recorded original, the stage enters DUP mode. It then replays the buffer
// one entry per accepted cycle. Each replayed entry has its registers remapped
// to the upper bank and its memory accesses remapped to the upper memory half.
// After the last duplicate it sits in DONE with qed_ready high until reset.
//
// Ports
//   clk                  in   clock
//   rst                  in   synchronous, active-high reset
//   ifu_qed_instruction  in   [31:0] constrained instruction from the harness
//   exec_dup             in   request to switch to duplicate mode
//   stall_IF             in   core fetch stall; freezes the whole stage
//   qed_instruction      out  [31:0] instruction presented to the core
//   qed_vld              out  qed_instruction is a real (non-NOP) instruction
//   qed_ready            out  every recorded original has been replayed
//   orig_count           out  [clog2(DEPTH):0] number of originals recorded
// ---------------------------------------------------------------------------
module qed_dup_replay #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] NOP_INSN = 32'h0000007F
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              ifu_qed_instruction,
    input  logic                     exec_dup,
    input  logic                     stall_IF,
    output logic [31:0]              qed_instruction,
    output logic                     qed_vld,
    output logic                     qed_ready,
    output logic [$clog2(DEPTH):0]   orig_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [6:0] NOP_OPC = NOP_INSN[6:0];

    typedef enum logic [1:0] {
        ORIG = 2'd0,
        DUP  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   orig_count_q, orig_count_d;
    logic [31:0]     insn_q, insn_d;
    logic            vld_q, vld_d;
    logic            ready_q, ready_d;

    logic [31:0]     buf_q [DEPTH];
    logic            buf_we;

    logic [31:0]     dup_insn;
    logic            last_dup;
    logic            in_is_nop;
    logic            buf_full;

    // Upper-bank register alias; x0 is shared between the two copies.
    function automatic logic [4:0] dup_reg(input logic [4:0] f);
        return (f == 5'd0) ? 5'd0 : (f | 5'b10000);
    endfunction

    // Opcode-directed remap of an original into its duplicate. Bit 26 adds 64
    // to the load/store immediate so the duplicate touches the upper memory
    // half.
    function automatic logic [31:0] remap(input logic [31:0] insn);
        logic [31:0] r;
        r = insn;
        case (insn[6:0])
            7'b0110011: begin
                r[11:7]  = dup_reg(insn[11:7]);
                r[19:15] = dup_reg(insn[19:15]);
                r[24:20] = dup_reg(insn[24:20]);
            end
            7'b0010011, 7'b1100111, 7'b0001111: begin
                r[11:7]  = dup_reg(insn[11:7]);
                r[19:15] = dup_reg(insn[19:15]);
            end
            7'b0000011: begin
                r[11:7]  = dup_reg(insn[11:7]);
                r[19:15] = dup_reg(insn[19:15]);
                r[26]    = 1'b1;
            end
            7'b0100011: begin
                r[19:15] = dup_reg(insn[19:15]);
                r[24:20] = dup_reg(insn[24:20]);
                r[26]    = 1'b1;
            end
            7'b1100011: begin
                r[19:15] = dup_reg(insn[19:15]);
                r[24:20] = dup_reg(insn[24:20]);
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                r[11:7]  = dup_reg(insn[11:7]);
            end
            default: r = insn;
        endcase
        return r;
    endfunction

    assign in_is_nop = (ifu_qed_instruction[6:0] == NOP_OPC);
    assign buf_full  = (orig_count_q >= CW'(DEPTH));
    // rd_ptr_q is 0 throughout ORIG, so the same read serves the first
    // duplicate issued on the ORIG->DUP edge.
    assign dup_insn  = remap(buf_q[rd_ptr_q]);
    // Widened compare so rd_ptr = DEPTH-1 does not wrap to 0.
    assign last_dup  = (({1'b0, rd_ptr_q} + CW'(1)) == orig_count_q);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        orig_count_d = orig_count_q;
        insn_d       = insn_q;
        vld_d        = vld_q;
        ready_d      = ready_q;
        buf_we       = 1'b0;

        if (!stall_IF) begin
            case (state_q)
                ORIG: begin
                    if (exec_dup && (orig_count_q != '0)) begin
                        // Switch cycle: the input is dropped and entry 0 issues.
                        insn_d   = dup_insn;
                        vld_d    = 1'b1;
                        ready_d  = last_dup;
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        state_d  = last_dup ? DONE : DUP;
                    end else if (!in_is_nop && !buf_full) begin
                        buf_we       = 1'b1;
                        wr_ptr_d     = wr_ptr_q + AW'(1);
                        orig_count_d = orig_count_q + CW'(1);
                        insn_d       = ifu_qed_instruction;
                        vld_d        = 1'b1;
                    end else begin
                        insn_d = NOP_INSN;
                        vld_d  = 1'b0;
                    end
                end
                DUP: begin
                    insn_d   = dup_insn;
                    vld_d    = 1'b1;
                    ready_d  = last_dup;
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (last_dup) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    insn_d  = NOP_INSN;
                    vld_d   = 1'b0;
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = ORIG;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ORIG;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            orig_count_q <= '0;
            insn_q       <= NOP_INSN;
            vld_q        <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            orig_count_q <= orig_count_d;
            insn_q       <= insn_d;
            vld_q        <= vld_d;
            ready_q      <= ready_d;
        end
    end

    // Buffer storage is not reset; orig_count defines which entries are valid.
    always_ff @(posedge clk) begin
        if (buf_we && !rst) begin
            buf_q[wr_ptr_q] <= ifu_qed_instruction;
        end
    end

    assign qed_instruction = insn_q;
    assign qed_vld         = vld_q;
    assign qed_ready       = ready_q;
    assign orig_count      = orig_count_q;

endmodule
